key_debounce_scan: RTL and testbench

KEY_DEBOUNCE_SCAN -- requirements
Module: key_debounce_scan

---
 rtl/key_debounce_scan.sv | 214 +++++++++++++++++++++
 tb/tb_key_debounce_scan.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_scan.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_scan
// Function : Time-multiplexed key debouncer; one key per cycle per scan tick.
//            Define KEY_EVENT_FIFO_EN to build the 8-deep change-event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_scan #(
    parameter int NUM_KEYS  = 61,
    parameter int TICK_DIV  = 15000,
    parameter int INTEG_MAX = 7
) (
    input  logic                clk_g_int_buf,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i_g,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                keys_update_o,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [7:0]          evt_key_o,
    output logic                evt_state_o,
    output logic                evt_overflow_o,
    output logic                tick_overrun_o
);

    localparam int c_IW = $clog2(INTEG_MAX + 1);
    localparam int c_XW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
    localparam logic [c_XW-1:0] c_IDX_LAST  = c_XW'(NUM_KEYS - 1);
    localparam logic [c_IW-1:0] c_IMAX      = c_IW'(INTEG_MAX);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [c_TW-1:0]     tick_cnt_q;
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [c_XW-1:0]     idx_q;
    logic [c_XW-1:0]     idx_d;
    logic [c_IW-1:0]     integ_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] shadow_q;
    logic [NUM_KEYS-1:0] keys_q;
    logic                upd_q;
    logic                ovr_q;

    logic                w_tick;
    logic                w_scan;
    logic                w_level;
    logic [c_IW-1:0]     w_cnt_cur;
    logic [c_IW-1:0]     w_cnt_new;
    logic                w_deb_cur;
    logic                w_deb_new;

    assign w_tick    = (tick_cnt_q == c_TICK_LAST);
    assign w_scan    = (state_q == c_SCAN);
    assign w_level   = sync2_q[idx_q];
    assign w_cnt_cur = integ_q[idx_q];
    assign w_deb_cur = shadow_q[idx_q];

    always_comb begin
        w_cnt_new = w_cnt_cur;
        if (w_level && (w_cnt_cur < c_IMAX)) begin
            w_cnt_new = w_cnt_cur + c_IW'(1);
        end else if (!w_level && (w_cnt_cur != '0)) begin
            w_cnt_new = w_cnt_cur - c_IW'(1);
        end
    end

    // Hysteresis: only the saturation end points flip the debounced bit.
    always_comb begin
        w_deb_new = w_deb_cur;
        if (w_cnt_new == c_IMAX) begin
            w_deb_new = 1'b1;
        end else if (w_cnt_new == '0) begin
            w_deb_new = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            c_IDLE: begin
                if (w_tick) begin
                    state_d = c_SCAN;
                    idx_d   = '0;
                end
            end
            c_SCAN: begin
                if (idx_q == c_IDX_LAST) begin
                    state_d = c_DONE;
                end else begin
                    idx_d = idx_q + c_XW'(1);
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            state_q    <= c_IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            keys_q     <= '0;
            upd_q      <= 1'b0;
            ovr_q      <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                integ_q[k] <= '0;
            end
        end else begin
            sync1_q    <= keys_i_g;
            sync2_q    <= sync1_q;
            tick_cnt_q <= w_tick ? '0 : tick_cnt_q + c_TW'(1);
            state_q    <= state_d;
            idx_q      <= idx_d;
            upd_q      <= (state_q == c_DONE);
            if (w_scan) begin
                integ_q[idx_q]  <= w_cnt_new;
                shadow_q[idx_q] <= w_deb_new;
            end
            if (state_q == c_DONE) begin
                keys_q <= shadow_q;
            end
            // A tick while busy is discarded rather than queued.
            if (w_tick && (state_q != c_IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign keys_o         = keys_q;
    assign keys_update_o  = upd_q;
    assign tick_overrun_o = ovr_q;

`ifdef KEY_EVENT_FIFO_EN
    logic       w_deb_chg;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       pend_q;
    logic [8:0] pend_data_q;
    logic [8:0] fifo_q [8];
    logic [2:0] wr_ptr_q;
    logic [2:0] rd_ptr_q;
    logic [3:0] fcnt_q;
    logic       ovf_q;

    assign w_deb_chg = w_scan && (w_deb_new != w_deb_cur);
    assign w_full    = (fcnt_q == 4'd8);
    assign w_pop     = (fcnt_q != 4'd0) && evt_ready_i;
    assign w_push    = pend_q && (!w_full || w_pop);

    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            ovf_q       <= 1'b0;
            for (int e = 0; e < 8; e++) begin
                fifo_q[e] <= '0;
            end
        end else begin
            pend_q      <= w_deb_chg;
            pend_data_q <= {8'(idx_q), w_deb_new};
            // When full with a pop, the write slot is the head being read out.
            if (w_push) begin
                fifo_q[wr_ptr_q] <= pend_data_q;
                wr_ptr_q         <= wr_ptr_q + 3'd1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 3'd1;
            end
            case ({w_push, w_pop})
                2'b10:   fcnt_q <= fcnt_q + 4'd1;
                2'b01:   fcnt_q <= fcnt_q - 4'd1;
                default: fcnt_q <= fcnt_q;
            endcase
            if (pend_q && w_full && !w_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign evt_valid_o              = (fcnt_q != 4'd0);
    assign {evt_key_o, evt_state_o} = fifo_q[rd_ptr_q];
    assign evt_overflow_o           = ovf_q;
`else
    logic w_unused_ready;

    assign w_unused_ready = evt_ready_i;
    assign evt_valid_o    = 1'b0;
    assign evt_key_o      = 8'd0;
    assign evt_state_o    = 1'b0;
    assign evt_overflow_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_scan
// Function : Scoreboard bench for key_debounce_scan (snapshots and events).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce_scan;

    localparam int NK = 61;
`ifdef KEY_EVENT_FIFO_EN
    localparam bit c_FIFO = 1'b1;
`else
    localparam bit c_FIFO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          rstn_ov;
    logic [NK-1:0] keys;
    logic [NK-1:0] keys_o;
    logic          keys_update;
    logic          evt_valid;
    logic          evt_ready;
    logic [7:0]    evt_key;
    logic          evt_state;
    logic          evt_ovf;
    logic          tick_ovr;

    logic [15:0]   ov_keys;
    logic [15:0]   ov_keys_o;
    logic          ov_upd;
    logic          ov_valid;
    logic [7:0]    ov_key;
    logic          ov_state;
    logic          ov_ovf;
    logic          ov_ovr;

    int n_chk   = 0;
    int n_err   = 0;
    int n_upd   = 0;
    int n_ovupd = 0;

    logic [NK-1:0] snap_q [$];
    logic [8:0]    evt_q  [$];

    always #5 clk = ~clk;

    key_debounce_scan #(.NUM_KEYS(NK), .TICK_DIV(100), .INTEG_MAX(7)) dut (
        .clk_g_int_buf (clk),
        .rstn_g_i      (rstn),
        .keys_i_g      (keys),
        .keys_o        (keys_o),
        .keys_update_o (keys_update),
        .evt_valid_o   (evt_valid),
        .evt_ready_i   (evt_ready),
        .evt_key_o     (evt_key),
        .evt_state_o   (evt_state),
        .evt_overflow_o(evt_ovf),
        .tick_overrun_o(tick_ovr)
    );

    // Deliberately illegal TICK_DIV == NUM_KEYS to force overruns.
    key_debounce_scan #(.NUM_KEYS(16), .TICK_DIV(16), .INTEG_MAX(3)) dut_ov (
        .clk_g_int_buf (clk),
        .rstn_g_i      (rstn_ov),
        .keys_i_g      (ov_keys),
        .keys_o        (ov_keys_o),
        .keys_update_o (ov_upd),
        .evt_valid_o   (ov_valid),
        .evt_ready_i   (1'b1),
        .evt_key_o     (ov_key),
        .evt_state_o   (ov_state),
        .evt_overflow_o(ov_ovf),
        .tick_overrun_o(ov_ovr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [NK-1:0] mask(input int lo, input int hi);
        logic [NK-1:0] m;
        m = '0;
        for (int b = lo; b <= hi; b++) m[b] = 1'b1;
        return m;
    endfunction

    task automatic push_evt(input int k, input bit s);
        if (c_FIFO) evt_q.push_back({8'(k), s});
    endtask

    // Returns one posedge (+1) after the target update was observed.
    task automatic wait_upd(input int target);
        int t;
        t = 0;
        while (n_upd < target && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (n_upd < target) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: update %0d not seen, got %0d", target, n_upd);
        end
        #1;
    endtask

    task automatic sweep(input logic [NK-1:0] drv, input logic [NK-1:0] exp);
        int target;
        target = n_upd + 1;
        keys = drv;
        snap_q.push_back(exp);
        wait_upd(target);
    endtask

    // Monitor: samples on the falling edge, where a valid&&ready pair means a pop next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (keys_update) begin
                n_upd++;
                if (snap_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL snapshot: unexpected update, keys_o=%0h required none", keys_o);
                end else begin
                    chk("snapshot", 64'(keys_o), 64'(snap_q.pop_front()));
                end
            end
            if (evt_valid && evt_ready) begin
                if (evt_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL event: unexpected pop key=%0d state=%0d, required none", evt_key, evt_state);
                end else begin
                    chk("event", 64'({evt_key, evt_state}), 64'(evt_q.pop_front()));
                end
            end
            if (ov_upd) n_ovupd++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NK-1:0] k;
        logic [NK-1:0] k2;
        logic [NK-1:0] k3;
        logic [NK-1:0] k4;
        logic [NK-1:0] kf;
        int target;
        int n;
        int base;

        rstn      = 1'b1;
        rstn_ov   = 1'b1;
        keys      = '0;
        ov_keys   = '0;
        evt_ready = 1'b0;
        #3;
        rstn    = 1'b0;
        rstn_ov = 1'b0;
        #1;
        chk("rst_keys_o", 64'(keys_o), 64'd0);
        chk("rst_update", 64'(keys_update), 64'd0);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_key", 64'(evt_key), 64'd0);
        chk("rst_state", 64'(evt_state), 64'd0);
        chk("rst_ovf", 64'(evt_ovf), 64'd0);
        chk("rst_overrun", 64'(tick_ovr), 64'd0);
        chk("ov_rst_overrun", 64'(ov_ovr), 64'd0);

        // Overrun instance: sweeps take 18 cycles against a 16-cycle tick.
        @(negedge clk);
        ov_keys = 16'h0080;
        rstn_ov = 1'b1;
        n = 0;
        while (n_ovupd < 1 && n < 200) begin @(posedge clk); n++; end
        chk("ov_overrun_after_sweep1", 64'(ov_ovr), 64'd1);
        n = 0;
        while (n_ovupd < 3 && n < 200) begin @(posedge clk); n++; end
        chk("ov_keys_after_sweep3", 64'(ov_keys_o), 64'h80);
        base = n_ovupd;
        repeat (320) @(negedge clk);
        @(posedge clk);
        chk("ov_sweeps_per_320", 64'(n_ovupd - base), 64'd10);

        // Key 5 held: rises on the 7th sweep.
        @(negedge clk);
        rstn      = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) sweep(mask(5, 5), '0);
        push_evt(5, 1'b1);
        sweep(mask(5, 5), mask(5, 5));
        chk("b_overrun", 64'(tick_ovr), 64'd0);
        chk("b_evt_drained", 64'(evt_q.size()), 64'd0);

        // Key 3 reaches saturation, then toggles each sweep without releasing.
        k = mask(5, 5) | mask(3, 3);
        for (int i = 0; i < 6; i++) sweep(k, mask(5, 5));
        push_evt(3, 1'b1);
        sweep(k, k);
        for (int i = 0; i < 6; i++) sweep((i % 2 == 0) ? mask(5, 5) : k, k);
        chk("c_no_events", 64'(evt_q.size()), 64'd0);

        // Eight keys fill the FIFO exactly, then a push coincides with a pop.
        evt_ready = 1'b0;
        k2 = k | mask(10, 17);
        for (int i = 0; i < 6; i++) sweep(k2, k);
        for (int i = 10; i <= 17; i++) push_evt(i, 1'b1);
        sweep(k2, k2);
        chk("e_full_valid", 64'(evt_valid), 64'(c_FIFO));
        chk("e_head_stable", 64'(evt_key), c_FIFO ? 64'd10 : 64'd0);
        chk("e_ovf_before", 64'(evt_ovf), 64'd0);
        k3 = k2 | mask(20, 20);
        for (int i = 0; i < 6; i++) sweep(k3, k2);
        push_evt(20, 1'b1);
        keys = k3;
        snap_q.push_back(k3);
        target = n_upd + 1;
        repeat (58) @(posedge clk);
        #1 evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        wait_upd(target);
        chk("e_ovf_after_push_pop", 64'(evt_ovf), 64'd0);
        chk("e_still_full", 64'(evt_valid), 64'(c_FIFO));
        evt_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("e_drained_valid", 64'(evt_valid), 64'd0);
        chk("e_drained_queue", 64'(evt_q.size()), 64'd0);

        // Ten simultaneous presses with the consumer stalled.
        evt_ready = 1'b0;
        k4 = k3 | mask(30, 39);
        for (int i = 0; i < 6; i++) sweep(k4, k3);
        for (int i = 30; i <= 37; i++) push_evt(i, 1'b1);
        sweep(k4, k4);
        chk("d_overflow", 64'(evt_ovf), 64'(c_FIFO));
        chk("d_valid", 64'(evt_valid), 64'(c_FIFO));
        chk("d_head", 64'(evt_key), c_FIFO ? 64'd30 : 64'd0);
        evt_ready = 1'b1;
        sweep(k4, k4);
        chk("d_drained", 64'(evt_q.size()), 64'd0);

        // Reset while index 30 is being processed.
        repeat (67) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("f_keys_o", 64'(keys_o), 64'd0);
        chk("f_update", 64'(keys_update), 64'd0);
        chk("f_valid", 64'(evt_valid), 64'd0);
        chk("f_key", 64'(evt_key), 64'd0);
        chk("f_ovf", 64'(evt_ovf), 64'd0);
        chk("f_overrun", 64'(tick_ovr), 64'd0);
        kf = mask(0, 0) | mask(60, 60);
        keys = kf;
        snap_q.push_back('0);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!keys_update && n < 400);
        chk("f_first_update_latency", 64'(n), 64'd162);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) sweep(kf, '0);
        push_evt(0, 1'b1);
        push_evt(60, 1'b1);
        sweep(kf, kf);
        repeat (5) @(posedge clk);
        #1;
        chk("end_snap_queue", 64'(snap_q.size()), 64'd0);
        chk("end_evt_queue", 64'(evt_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
